// File: rtl/simplez_sequencer.sv
// SIMPLEZ control unit: fetch / decode / operand FSM issuing combinational microorders.
// State and the fetch counter advance on the falling clock edge, in step with the datapath.
module simplez_sequencer #(
  parameter int OPW  = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            ac_zero,
  input  logic            mem_rdy,
  output logic            lec,
  output logic            esc,
  output logic            era,
  output logic            incp,
  output logic            ecp,
  output logic            ccp,
  output logic            scp,
  output logic            eri,
  output logic            sri,
  output logic            eac,
  output logic            sac,
  output logic [1:0]      alu_op,
  output logic            stop,
  output logic [2:0]      state_o,
  output logic [CNTW-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_I0   = 3'd1,
    S_I1   = 3'd2,
    S_O0   = 3'd3,
    S_O1   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [OPW-1:0] OP_ST  = OPW'(0);
  localparam logic [OPW-1:0] OP_LD  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_BR  = OPW'(3);
  localparam logic [OPW-1:0] OP_BZ  = OPW'(4);
  localparam logic [OPW-1:0] OP_CLR = OPW'(5);
  localparam logic [OPW-1:0] OP_DEC = OPW'(6);

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_DEC  = 2'b10;
  localparam logic [1:0] ALU_ZERO = 2'b11;

  state_t          r_state;
  state_t          w_next;
  logic [CNTW-1:0] r_cnt;

  always_comb begin
    lec    = 1'b0;
    esc    = 1'b0;
    era    = 1'b0;
    incp   = 1'b0;
    ecp    = 1'b0;
    ccp    = 1'b0;
    scp    = 1'b0;
    eri    = 1'b0;
    sri    = 1'b0;
    eac    = 1'b0;
    sac    = 1'b0;
    alu_op = ALU_PASS;
    stop   = 1'b0;
    w_next = r_state;
    case (r_state)
      S_INIT: begin
        ccp    = 1'b1;
        w_next = S_O1;
      end
      S_I0: begin
        lec = 1'b1;
        if (mem_rdy) begin
          eri    = 1'b1;
          incp   = 1'b1;
          w_next = S_I1;
        end
      end
      S_I1: begin
        case (opcode)
          OP_ST, OP_LD, OP_ADD: begin
            sri    = 1'b1;
            era    = 1'b1;
            w_next = S_O0;
          end
          OP_BR: begin
            sri    = 1'b1;
            era    = 1'b1;
            ecp    = 1'b1;
            w_next = S_I0;
          end
          OP_BZ: begin
            if (ac_zero) begin
              sri    = 1'b1;
              era    = 1'b1;
              ecp    = 1'b1;
              w_next = S_I0;
            end else begin
              w_next = S_O1;
            end
          end
          OP_CLR: begin
            eac    = 1'b1;
            alu_op = ALU_ZERO;
            w_next = S_O1;
          end
          OP_DEC: begin
            eac    = 1'b1;
            alu_op = ALU_DEC;
            w_next = S_O1;
          end
          // HLT and any undecodable opcode both stop the machine
          default: w_next = S_HALT;
        endcase
      end
      S_O0: begin
        case (opcode)
          OP_ST: begin
            sac = 1'b1;
            esc = 1'b1;
          end
          OP_LD: begin
            lec = 1'b1;
            if (mem_rdy) begin
              eac    = 1'b1;
              alu_op = ALU_PASS;
            end
          end
          OP_ADD: begin
            lec = 1'b1;
            if (mem_rdy) begin
              eac    = 1'b1;
              alu_op = ALU_ADD;
            end
          end
          default: ;
        endcase
        if (mem_rdy) w_next = S_O1;
      end
      S_O1: begin
        scp    = 1'b1;
        era    = 1'b1;
        w_next = S_I0;
      end
      S_HALT: begin
        stop   = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_I0 && mem_rdy) r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign state_o   = r_state;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_simplez_sequencer.sv
// Bench for simplez_sequencer: per-cycle vector table plus hand sequences for stalls,
// counter wrap (CNTW=4 copy), HALT and asynchronous reset mid-operation.
module tb_simplez_sequencer;

  localparam logic [13:0] LEC  = 14'h2000;
  localparam logic [13:0] ESC  = 14'h1000;
  localparam logic [13:0] ERA  = 14'h0800;
  localparam logic [13:0] INCP = 14'h0400;
  localparam logic [13:0] ECP  = 14'h0200;
  localparam logic [13:0] CCP  = 14'h0100;
  localparam logic [13:0] SCP  = 14'h0080;
  localparam logic [13:0] ERI  = 14'h0040;
  localparam logic [13:0] SRI  = 14'h0020;
  localparam logic [13:0] EAC  = 14'h0010;
  localparam logic [13:0] SAC  = 14'h0008;
  localparam logic [13:0] ALU1 = 14'h0002;
  localparam logic [13:0] ALU2 = 14'h0004;
  localparam logic [13:0] ALU3 = 14'h0006;
  localparam logic [13:0] STOP = 14'h0001;
  localparam logic [13:0] I0F  = LEC | ERI | INCP;
  localparam logic [13:0] NONE = 14'h0000;

  typedef struct {
    logic [2:0]  op;
    logic        az;
    logic        rdy;
    logic [2:0]  st;
    logic [13:0] w;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [13:0] w;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic        ac_zero = 1'b0;
  logic        mem_rdy = 1'b0;

  logic lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac, stop;
  logic [1:0]  alu_op;
  logic [2:0]  state_o;
  logic [15:0] instr_cnt;

  logic d4_lec, d4_esc, d4_era, d4_incp, d4_ecp, d4_ccp, d4_scp, d4_eri, d4_sri, d4_eac, d4_sac, d4_stop;
  logic [1:0]  d4_alu_op;
  logic [2:0]  d4_state;
  logic [3:0]  d4_cnt;

  logic [13:0] w_act, w_act4;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  simplez_sequencer #(.OPW(3), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ac_zero(ac_zero), .mem_rdy(mem_rdy),
    .lec(lec), .esc(esc), .era(era), .incp(incp), .ecp(ecp), .ccp(ccp), .scp(scp),
    .eri(eri), .sri(sri), .eac(eac), .sac(sac), .alu_op(alu_op), .stop(stop),
    .state_o(state_o), .instr_cnt(instr_cnt)
  );

  simplez_sequencer #(.OPW(3), .CNTW(4)) u_dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .ac_zero(ac_zero), .mem_rdy(mem_rdy),
    .lec(d4_lec), .esc(d4_esc), .era(d4_era), .incp(d4_incp), .ecp(d4_ecp), .ccp(d4_ccp),
    .scp(d4_scp), .eri(d4_eri), .sri(d4_sri), .eac(d4_eac), .sac(d4_sac), .alu_op(d4_alu_op),
    .stop(d4_stop), .state_o(d4_state), .instr_cnt(d4_cnt)
  );

  assign w_act  = {lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac, alu_op, stop};
  assign w_act4 = {d4_lec, d4_esc, d4_era, d4_incp, d4_ecp, d4_ccp, d4_scp, d4_eri, d4_sri,
                   d4_eac, d4_sac, d4_alu_op, d4_stop};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [2:0] op, input logic az, input logic rdy,
                       input logic [2:0] st, input logic [13:0] w);
    exp_t e;
    exp_t g;
    @(posedge clk);
    opcode  = op;
    ac_zero = az;
    mem_rdy = rdy;
    e.st  = st;
    e.w   = w;
    e.cnt = exp_cnt;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk("state", 32'(state_o), 32'(g.st));
    chk("uorders", 32'(w_act), 32'(g.w));
    chk("cnt16", 32'(instr_cnt), 32'(g.cnt));
    chk("state4", 32'(d4_state), 32'(g.st));
    chk("uorders4", 32'(w_act4), 32'(g.w));
    chk("cnt4", 32'(d4_cnt), 32'(g.cnt[3:0]));
    chk("invariants", 32'({eac & sac, lec & esc, scp & sri}), 32'(0));
    if (st == 3'd1 && rdy) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic reset_hold();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    exp_cnt = 16'd0;
  endtask

  initial begin
    vec_t tbl[34];
    tbl = '{
      '{3'd0, 1'b0, 1'b1, 3'd0, CCP},
      '{3'd0, 1'b0, 1'b1, 3'd4, SCP | ERA},
      '{3'd1, 1'b0, 1'b1, 3'd1, I0F},
      '{3'd1, 1'b0, 1'b1, 3'd2, SRI | ERA},
      '{3'd1, 1'b0, 1'b1, 3'd3, LEC | EAC},
      '{3'd1, 1'b0, 1'b1, 3'd4, SCP | ERA},
      '{3'd2, 1'b0, 1'b1, 3'd1, I0F},
      '{3'd2, 1'b0, 1'b1, 3'd2, SRI | ERA},
      '{3'd2, 1'b0, 1'b1, 3'd3, LEC | EAC | ALU1},
      '{3'd2, 1'b0, 1'b1, 3'd4, SCP | ERA},
      '{3'd0, 1'b0, 1'b1, 3'd1, I0F},
      '{3'd0, 1'b0, 1'b1, 3'd2, SRI | ERA},
      '{3'd0, 1'b0, 1'b0, 3'd3, SAC | ESC},
      '{3'd0, 1'b0, 1'b1, 3'd3, SAC | ESC},
      '{3'd0, 1'b0, 1'b1, 3'd4, SCP | ERA},
      '{3'd3, 1'b0, 1'b1, 3'd1, I0F},
      '{3'd3, 1'b0, 1'b1, 3'd2, SRI | ERA | ECP},
      '{3'd4, 1'b1, 1'b1, 3'd1, I0F},
      '{3'd4, 1'b1, 1'b1, 3'd2, SRI | ERA | ECP},
      '{3'd4, 1'b0, 1'b1, 3'd1, I0F},
      '{3'd4, 1'b0, 1'b1, 3'd2, NONE},
      '{3'd4, 1'b0, 1'b1, 3'd4, SCP | ERA},
      '{3'd5, 1'b1, 1'b1, 3'd1, I0F},
      '{3'd5, 1'b1, 1'b1, 3'd2, EAC | ALU3},
      '{3'd5, 1'b0, 1'b1, 3'd4, SCP | ERA},
      '{3'd6, 1'b0, 1'b1, 3'd1, I0F},
      '{3'd6, 1'b0, 1'b1, 3'd2, EAC | ALU2},
      '{3'd6, 1'b0, 1'b1, 3'd4, SCP | ERA},
      '{3'd1, 1'b0, 1'b0, 3'd1, LEC},
      '{3'd1, 1'b0, 1'b1, 3'd1, I0F},
      '{3'd1, 1'b0, 1'b1, 3'd2, SRI | ERA},
      '{3'd1, 1'b0, 1'b0, 3'd3, LEC},
      '{3'd1, 1'b0, 1'b1, 3'd3, LEC | EAC},
      '{3'd1, 1'b0, 1'b1, 3'd4, SCP | ERA}
    };

    #1;
    reset_hold();
    for (int i = 0; i < 34; i++)
      apply(tbl[i].op, tbl[i].az, tbl[i].rdy, tbl[i].st, tbl[i].w);

    // fetch stall: three wait cycles, then a single eri/incp pulse
    for (int i = 0; i < 3; i++) apply(3'd5, 1'b0, 1'b0, 3'd1, LEC);
    apply(3'd5, 1'b0, 1'b1, 3'd1, I0F);
    apply(3'd5, 1'b0, 1'b0, 3'd2, EAC | ALU3);
    apply(3'd5, 1'b0, 1'b0, 3'd4, SCP | ERA);

    // branch loop: enough fetches to wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      apply(3'd3, 1'b0, 1'b1, 3'd1, I0F);
      apply(3'd3, 1'b0, 1'b1, 3'd2, SRI | ERA | ECP);
    end

    // HALT: stays stopped with inputs toggling, counter frozen
    apply(3'd7, 1'b0, 1'b1, 3'd1, I0F);
    apply(3'd7, 1'b0, 1'b1, 3'd2, NONE);
    for (int i = 0; i < 100; i++)
      apply(3'($urandom), 1'($urandom), 1'(i % 2), 3'd5, STOP);
    #1 rst = 1'b1;
    #1;
    chk("halt_rst_state", 32'(state_o), 32'(0));
    chk("halt_rst_stop", 32'(stop), 32'(0));
    chk("halt_rst_ccp", 32'(ccp), 32'(1));
    chk("halt_rst_cnt", 32'(instr_cnt), 32'(0));
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    exp_cnt = 16'd0;

    // reset arriving during an ST wait state
    apply(3'd0, 1'b0, 1'b1, 3'd0, CCP);
    apply(3'd0, 1'b0, 1'b1, 3'd4, SCP | ERA);
    apply(3'd0, 1'b0, 1'b1, 3'd1, I0F);
    apply(3'd0, 1'b0, 1'b0, 3'd2, SRI | ERA);
    apply(3'd0, 1'b0, 1'b0, 3'd3, SAC | ESC);
    apply(3'd0, 1'b0, 1'b0, 3'd3, SAC | ESC);
    #1 rst = 1'b1;
    #1;
    chk("st_rst_esc", 32'(esc), 32'(0));
    chk("st_rst_sac", 32'(sac), 32'(0));
    chk("st_rst_state", 32'(state_o), 32'(0));
    chk("st_rst_cnt", 32'(instr_cnt), 32'(0));
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    exp_cnt = 16'd0;
    apply(3'd0, 1'b0, 1'b0, 3'd0, CCP);
    apply(3'd0, 1'b0, 1'b0, 3'd4, SCP | ERA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
